seq_alu: RTL and testbench
==========================

SEQ_ALU -- requirements
Module: seq_alu

Interface
REQ-001 SHALL define parameter WIDTH, default 32: operand and result width.
REQ-002 SHALL define parameter SHW, default 5: shift-amount width.
REQ-003 SHALL provide port clk, input, 1 bit: single clock; all state changes on its rising edge.
REQ-004 SHALL provide port reset, input, 1 bit: asynchronous, active-low reset.
REQ-005 SHALL provide port in_valid, input, 1 bit: request operands valid.
REQ-006 SHALL provide port in_ready, output, 1 bit: block can accept a request.
REQ-007 SHALL provide port A, input, WIDTH bits: operand A.
REQ-008 SHALL provide port B, input, WIDTH bits: operand B; shifts use B[SHW-1:0].
REQ-009 SHALL provide port ALUOp, input, 3 bits: operation code.
REQ-010 SHALL provide port out_valid, output, 1 bit: result C valid.
REQ-011 SHALL provide port out_ready, input, 1 bit: consumer accepts the result.
REQ-012 SHALL provide port C, output, WIDTH bits: result.
REQ-013 SHALL provide port busy, output, 1 bit: high in every state except IDLE.

Function
REQ-014 SHALL decode ALUOp as: 0 add, 1 sub, 2 and, 3 or, 4 srl, 5 sra, 6 sll, 7 sltu (C = {0..., A<B unsigned}).
REQ-015 SHALL compute add and sub modulo 2^WIDTH, with no carry or overflow output.
REQ-016 SHALL implement a state machine with states IDLE, SHIFT, DONE.
REQ-017 SHALL drive in_ready = 1 only in IDLE.
REQ-018 SHALL accept a request on a cycle with in_valid and in_ready both high, and register A, B[SHW-1:0] and ALUOp on that cycle.
REQ-019 SHALL, for a non-shift op or a shift with amount 0, go IDLE -> DONE with C loaded with the final result; out_valid is high on the cycle after acceptance.
REQ-020 SHALL, for a shift with nonzero amount N, go IDLE -> SHIFT, shift the working register one bit per cycle, and count the amount down to 0; after the Nth step it goes SHIFT -> DONE, and out_valid is high N+1 cycles after acceptance.
REQ-021 SHALL fill vacated bits as follows: srl fills with 0, sll fills with 0, sra fills with the original A[WIDTH-1].
REQ-022 SHALL hold C and out_valid stable in DONE until out_ready = 1.
REQ-023 SHALL go DONE -> IDLE on the cycle out_valid and out_ready are both high.
REQ-024 SHALL keep out_valid = 0 in IDLE and SHIFT.
REQ-025 SHALL ignore in_valid while busy; no request is queued.
REQ-026 SHALL ignore changes on A, B or ALUOp after acceptance until the next acceptance.

Reset
REQ-027 SHALL, on reset low at any time including mid-SHIFT or in DONE, immediately force: state IDLE, C = 0, out_valid = 0, busy = 0, shift count = 0.
REQ-028 SHALL make in_ready = 1 on the first cycle after reset is released, and SHALL discard any in-flight result.

Structure
REQ-029 SHALL place the opcode constants (OP_ADD..OP_SLTU) and the state encoding (IDLE, SHIFT, DONE) in shared package alu_pkg.
REQ-030 SHALL implement the single-cycle ops (add, sub, and, or, sltu) in one combinational sub-module alu_comb; seq_alu owns the state machine, counter and shift register.
REQ-031 SHALL contain no latches; all outputs are registered except in_ready and busy, which are decoded from state.

Verification
REQ-032 SHALL cover: A=32'hf0ffffff, B=3, ALUOp=5 accepted -> out_valid 4 cycles later, C=32'hfe1fffff.
REQ-033 SHALL cover: same operands with ALUOp=4 -> C=32'h1e1fffff after 4 cycles; with ALUOp=6 -> C=32'h87fffff8.
REQ-034 SHALL cover: A=32'hffffffff, B=1, ALUOp=0 -> C=0 one cycle later; A=0, B=1, ALUOp=1 -> C=32'hffffffff; ALUOp=7 with A=1, B=2 -> C=1.
REQ-035 SHALL cover: a shift with B=0 -> 1-cycle latency, C=A; a shift with B=31, A=32'h80000000, ALUOp=5 -> C=32'hffffffff after 32 cycles.
REQ-036 SHALL cover: out_ready held 0 for 5 cycles in DONE -> C and out_valid stable, in_ready 0, and a new in_valid pulse is ignored; then out_ready=1 -> IDLE the next cycle.
REQ-037 SHALL cover: reset asserted at shift step 2 of 10 -> outputs zero immediately; after release, a new add request completes correctly.

Source files
------------

// File: rtl/alu_pkg.sv
// Shared opcode constants, state encoding and opcode helper for the sequential ALU.
package alu_pkg;

    localparam logic [2:0] OP_ADD  = 3'd0;
    localparam logic [2:0] OP_SUB  = 3'd1;
    localparam logic [2:0] OP_AND  = 3'd2;
    localparam logic [2:0] OP_OR   = 3'd3;
    localparam logic [2:0] OP_SRL  = 3'd4;
    localparam logic [2:0] OP_SRA  = 3'd5;
    localparam logic [2:0] OP_SLL  = 3'd6;
    localparam logic [2:0] OP_SLTU = 3'd7;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DONE  = 2'd2
    } state_t;

    function automatic logic is_shift(input logic [2:0] op);
        return (op == OP_SRL) || (op == OP_SRA) || (op == OP_SLL);
    endfunction

endpackage

// File: rtl/alu_comb.sv
// Single-cycle ALU datapath: add, sub, and, or, unsigned set-less-than.
// Shift opcodes are handled bit-serially by seq_alu and yield zero here.
module alu_comb
    import alu_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic [2:0]       op,
    output logic [WIDTH-1:0] y
);

    // Opcode decode for the operations that finish in one cycle.
    always_comb begin
        y = {WIDTH{1'b0}};
        case (op)
            OP_ADD:  y = a + b;
            OP_SUB:  y = a - b;
            OP_AND:  y = a & b;
            OP_OR:   y = a | b;
            OP_SLTU: y = {{(WIDTH-1){1'b0}}, (a < b)};
            default: y = {WIDTH{1'b0}};
        endcase
    end

endmodule

// File: rtl/seq_alu.sv
// Sequential ALU: single-cycle ops complete in one step, shifts move one bit per
// cycle; valid/ready handshake on both sides, result held in DONE until consumed.
module seq_alu
    import alu_pkg::*;
#(
    parameter int WIDTH = 32,
    parameter int SHW   = 5
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    input  logic [2:0]       ALUOp,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] C,
    output logic             busy
);

    localparam logic [SHW-1:0] CNT_ZERO = {SHW{1'b0}};
    localparam logic [SHW-1:0] CNT_ONE  = SHW'(1'b1);

    state_t           state_q, state_d;
    logic [WIDTH-1:0] work_q, work_d;
    logic [SHW-1:0]   cnt_q, cnt_d;
    logic [2:0]       op_q, op_d;
    logic             fill_q, fill_d;
    logic [WIDTH-1:0] c_q, c_d;
    logic             out_valid_q, out_valid_d;
    logic [WIDTH-1:0] alu_y_s;
    logic [WIDTH-1:0] shifted_s;

    alu_comb #(.WIDTH(WIDTH)) u_alu_comb (
        .a  (A),
        .b  (B),
        .op (ALUOp),
        .y  (alu_y_s)
    );

    // One-bit step of the working register; fill_q carries the sign captured at acceptance.
    always_comb begin
        shifted_s = work_q;
        case (op_q)
            OP_SRL:  shifted_s = {1'b0, work_q[WIDTH-1:1]};
            OP_SRA:  shifted_s = {fill_q, work_q[WIDTH-1:1]};
            OP_SLL:  shifted_s = {work_q[WIDTH-2:0], 1'b0};
            default: shifted_s = work_q;
        endcase
    end

    // Next-state logic for the IDLE -> (SHIFT) -> DONE sequence.
    always_comb begin
        state_d     = state_q;
        work_d      = work_q;
        cnt_d       = cnt_q;
        op_d        = op_q;
        fill_d      = fill_q;
        c_d         = c_q;
        out_valid_d = out_valid_q;
        case (state_q)
            IDLE: begin
                if (in_valid) begin
                    op_d   = ALUOp;
                    work_d = A;
                    cnt_d  = B[SHW-1:0];
                    fill_d = (ALUOp == OP_SRA) ? A[WIDTH-1] : 1'b0;
                    if (is_shift(ALUOp) && (B[SHW-1:0] != CNT_ZERO)) begin
                        state_d = SHIFT;
                    end else begin
                        state_d     = DONE;
                        out_valid_d = 1'b1;
                        c_d         = is_shift(ALUOp) ? A : alu_y_s;
                    end
                end else begin
                    state_d = IDLE;
                end
            end
            SHIFT: begin
                work_d = shifted_s;
                cnt_d  = cnt_q - CNT_ONE;
                if (cnt_q == CNT_ONE) begin
                    state_d     = DONE;
                    out_valid_d = 1'b1;
                    c_d         = shifted_s;
                end else begin
                    state_d = SHIFT;
                end
            end
            DONE: begin
                if (out_ready) begin
                    state_d     = IDLE;
                    out_valid_d = 1'b0;
                end else begin
                    state_d = DONE;
                end
            end
            default: begin
                state_d     = IDLE;
                out_valid_d = 1'b0;
                cnt_d       = CNT_ZERO;
            end
        endcase
    end

    // State and datapath registers; reset drops any in-flight operation.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q     <= IDLE;
            work_q      <= {WIDTH{1'b0}};
            cnt_q       <= CNT_ZERO;
            op_q        <= OP_ADD;
            fill_q      <= 1'b0;
            c_q         <= {WIDTH{1'b0}};
            out_valid_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            work_q      <= work_d;
            cnt_q       <= cnt_d;
            op_q        <= op_d;
            fill_q      <= fill_d;
            c_q         <= c_d;
            out_valid_q <= out_valid_d;
        end
    end

    assign in_ready  = (state_q == IDLE);
    assign busy      = (state_q != IDLE);
    assign out_valid = out_valid_q;
    assign C         = c_q;

endmodule

// File: tb/tb_seq_alu.sv
// Scoreboard bench for seq_alu: directed corner cases plus random traffic
// against a plain-arithmetic reference model.
module tb_seq_alu;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [31:0] A = 32'd0;
    logic [31:0] B = 32'd0;
    logic [2:0]  ALUOp = 3'd0;
    logic        out_valid;
    logic        out_ready = 1'b0;
    logic [31:0] C;
    logic        busy;

    typedef struct {
        logic [31:0] c;
        int          due;
    } exp_t;

    exp_t exp_q[$];
    int   n_cmp = 0;
    int   n_bad = 0;
    int   cyc = 0;
    int   ready_mode = 0;
    logic ov_prev = 1'b0;

    seq_alu #(.WIDTH(32), .SHW(5)) dut (
        .clk       (clk),
        .reset     (reset),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .A         (A),
        .B         (B),
        .ALUOp     (ALUOp),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .C         (C),
        .busy      (busy)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    function automatic logic [31:0] ref_alu(input logic [31:0] a, input logic [31:0] b,
                                            input logic [2:0] op);
        case (op)
            3'd0:    return a + b;
            3'd1:    return a - b;
            3'd2:    return a & b;
            3'd3:    return a | b;
            3'd4:    return a >> b[4:0];
            3'd5:    return $unsigned($signed(a) >>> b[4:0]);
            3'd6:    return a << b[4:0];
            default: return (a < b) ? 32'd1 : 32'd0;
        endcase
    endfunction

    function automatic int ref_lat(input logic [31:0] b, input logic [2:0] op);
        return (op >= 3'd4 && op <= 3'd6) ? int'(b[4:0]) : 0;
    endfunction

    // Wait for in_ready, present one request, push its expected result and due cycle.
    task automatic issue(input logic [31:0] a, input logic [31:0] b, input logic [2:0] op,
                         input logic [31:0] exp_c);
        int   g;
        exp_t e;
        g = 0;
        @(negedge clk);
        while (!in_ready && g < 200) begin
            @(negedge clk);
            g++;
        end
        if (!in_ready) begin
            check("issue_timeout", 32'd0, 32'd1);
            return;
        end
        A = a;
        B = b;
        ALUOp = op;
        in_valid = 1'b1;
        e.c = exp_c;
        e.due = cyc + 1 + ref_lat(b, op);
        exp_q.push_back(e);
        @(negedge clk);
        in_valid = 1'b0;
        A = $urandom;
        B = $urandom;
        ALUOp = 3'($urandom_range(0, 7));
    endtask

    task automatic drain();
        int g;
        g = 0;
        while (exp_q.size() != 0 && g < 300) begin
            @(negedge clk);
            g++;
        end
        check("drain", 32'(exp_q.size()), 32'd0);
    endtask

    // Monitor: compare C and first-valid timing, then choose out_ready and retire on handshake.
    always @(negedge clk) begin
        if (reset) begin
            if (out_valid) begin
                if (exp_q.size() == 0) begin
                    check("unexpected_valid", 32'd1, 32'd0);
                end else begin
                    check("C", C, exp_q[0].c);
                    if (!ov_prev) check("latency_cycle", 32'(cyc), 32'(exp_q[0].due));
                end
            end
            ov_prev = out_valid;
            case (ready_mode)
                0:       out_ready = 1'b1;
                1:       out_ready = 1'($urandom_range(0, 1));
                default: out_ready = 1'b0;
            endcase
            if (out_valid && out_ready && exp_q.size() != 0) void'(exp_q.pop_front());
        end else begin
            ov_prev = 1'b0;
        end
    end

    initial begin
        #300000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [31:0] ra, rb;
        logic [2:0]  rop;

        repeat (3) @(negedge clk);
        check("rst_out_valid", 32'(out_valid), 32'd0);
        check("rst_C", C, 32'd0);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_in_ready", 32'(in_ready), 32'd1);
        reset = 1'b1;

        issue(32'hf0ffffff, 32'd3, 3'd5, 32'hfe1fffff);
        issue(32'hf0ffffff, 32'd3, 3'd4, 32'h1e1fffff);
        issue(32'hf0ffffff, 32'd3, 3'd6, 32'h87fffff8);
        issue(32'hffffffff, 32'd1, 3'd0, 32'h00000000);
        issue(32'h00000000, 32'd1, 3'd1, 32'hffffffff);
        issue(32'h00000001, 32'd2, 3'd7, 32'h00000001);
        issue(32'h00000002, 32'd1, 3'd7, 32'h00000000);
        issue(32'h12345678, 32'd0, 3'd4, 32'h12345678);
        issue(32'h80000000, 32'd31, 3'd5, 32'hffffffff);
        issue(32'h80000001, 32'h00000021, 3'd4, 32'h40000000);
        drain();

        // Hold the result in DONE and try to sneak in a second request.
        ready_mode = 2;
        issue(32'h0f0f00ff, 32'h00ff0ff0, 3'd3, 32'h0fff0fff);
        check("hold_valid_0", 32'(out_valid), 32'd1);
        in_valid = 1'b1;
        A = 32'h11111111;
        B = 32'h22222222;
        ALUOp = 3'd0;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            in_valid = 1'b0;
            check("hold_in_ready", 32'(in_ready), 32'd0);
            check("hold_valid", 32'(out_valid), 32'd1);
        end
        #1 ready_mode = 0;
        @(negedge clk);
        check("release_in_ready_before", 32'(in_ready), 32'd0);
        @(negedge clk);
        check("release_in_ready", 32'(in_ready), 32'd1);
        check("release_valid", 32'(out_valid), 32'd0);
        check("release_busy", 32'(busy), 32'd0);
        drain();

        ready_mode = 1;
        for (int i = 0; i < 40; i++) begin
            ra = $urandom;
            rb = (i % 3 == 0) ? 32'($urandom_range(0, 3)) : $urandom;
            rop = 3'($urandom_range(0, 7));
            issue(ra, rb, rop, ref_alu(ra, rb, rop));
        end
        ready_mode = 0;
        drain();

        // Reset during the second step of a 10-step shift.
        issue(32'h00000f0f, 32'd10, 3'd6, 32'h003c3c00);
        @(negedge clk);
        check("mid_shift_busy", 32'(busy), 32'd1);
        #2 reset = 1'b0;
        #1;
        check("mid_rst_out_valid", 32'(out_valid), 32'd0);
        check("mid_rst_C", C, 32'd0);
        check("mid_rst_busy", 32'(busy), 32'd0);
        check("mid_rst_in_ready", 32'(in_ready), 32'd1);
        exp_q.delete();
        @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        check("post_rst_in_ready", 32'(in_ready), 32'd1);
        check("post_rst_out_valid", 32'(out_valid), 32'd0);
        issue(32'h7fffffff, 32'd1, 3'd0, 32'h80000000);
        drain();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
